// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
// Data-SRAM request/response bus between the EX-stage access unit and the
// data memory.
//
// Handshake: data_req is held high with all request fields constant until a
// cycle in which data_addr_ok=1; that cycle transfers the request. Exactly one
// data_data_ok pulse follows per accepted request (loads and stores), and it
// may arrive in the same cycle as data_addr_ok. data_rdata is valid only in
// the data_data_ok cycle.
//
// Signals
//   data_req      master->slave  request valid
//   data_wr       master->slave  1=store, 0=load
//   data_size     master->slave  0=byte 1=half 2=word
//   data_addr     master->slave  full byte address
//   data_wstrb    master->slave  byte strobes (0000 for loads)
//   data_wdata    master->slave  lane-replicated store data
//   data_addr_ok  slave->master  request accepted this cycle
//   data_data_ok  slave->master  response this cycle
//   data_rdata    slave->master  load data
// ---------------------------------------------------------------------------
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
// Issues EX-stage loads/stores to the data SRAM, aligns store data/strobes,
// stalls the pipeline while an access is outstanding and holds the raw load
// word until the EX->MEM register latches it (MEM does byte/half extraction).
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are not issued; addr_exc flags
//               them combinationally while EX holds the op.
//   undefined : addr_exc tied 0; low address bits are cleared for half/word
//               and the access proceeds.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   ex_valid   EX holds a valid instruction (stable while stallreq=1)
//   ex_mem_op  one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw}; zero = no memory op
//   ex_addr    effective address
//   ex_wdata   store source value
//   pipe_adv   EX->MEM register latches this cycle
//   flush      kill the current EX instruction
//   bus        data-SRAM bus (master side)
//   stallreq   stall request to the stall controller
//   ld_rdata   captured raw load word
//   ld_valid   ld_rdata valid (state DONE)
//   addr_exc   misaligned access flag
//   dbg_state  current FSM state (IDLE=0 REQ=1 WAIT=2 DONE=3 DRAIN=4)
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [7:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              pipe_adv,
  input  logic              flush,
  dmem_access_unit_if.master bus,
  output logic              stallreq,
  output logic [31:0]       ld_rdata,
  output logic              ld_valid,
  output logic              addr_exc,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state, state_n;

  // ------------------------------------------------------------------
  // Op decode of the one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw} vector
  // ------------------------------------------------------------------
  logic op_any, op_byte, op_half, op_word, op_store;

  assign op_any   = |ex_mem_op;
  assign op_byte  = ex_mem_op[7] | ex_mem_op[6] | ex_mem_op[2];
  assign op_half  = ex_mem_op[5] | ex_mem_op[4] | ex_mem_op[1];
  assign op_word  = ex_mem_op[3] | ex_mem_op[0];
  assign op_store = ex_mem_op[2] | ex_mem_op[1] | ex_mem_op[0];

  // ------------------------------------------------------------------
  // Alignment handling
  // ------------------------------------------------------------------
  logic              exc;
  logic [ADDR_W-1:0] acc_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (op_half & ex_addr[0]) |
                      (op_word & (ex_addr[1:0] != 2'b00));
  assign exc        = misaligned;
  assign acc_addr   = ex_addr;
`else
  assign exc = 1'b0;
  // Clear the sub-width address bits so the bus always sees an aligned address.
  always_comb begin
    acc_addr = ex_addr;
    if (op_half) acc_addr[0]   = 1'b0;
    if (op_word) acc_addr[1:0] = 2'b00;
  end
`endif

  // Accept is gated by rst so stallreq stays low while reset is asserted.
  logic accept;
  assign accept = rst & (state == IDLE) & ex_valid & op_any & ~flush & ~exc;

  // ------------------------------------------------------------------
  // Store data / strobe alignment (computed on the EX inputs, latched on accept)
  // ------------------------------------------------------------------
  logic [1:0]  acc_size;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata;

  always_comb begin
    acc_size  = 2'd2;
    acc_wstrb = 4'b0000;
    acc_wdata = 32'h0;
    if (op_byte) begin
      acc_size = 2'd0;
      if (op_store) begin
        acc_wstrb = 4'b0001 << ex_addr[1:0];
        acc_wdata = {4{ex_wdata[7:0]}};
      end
    end else if (op_half) begin
      acc_size = 2'd1;
      if (op_store) begin
        acc_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{ex_wdata[15:0]}};
      end
    end else begin
      acc_size = 2'd2;
      if (op_store) begin
        acc_wstrb = 4'b1111;
        acc_wdata = ex_wdata;
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // A flush after the bus has taken the request cannot cancel it, so the
  // response is drained; a flush coinciding with the response just drops it.
  // ------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) state_n = REQ;
      end
      REQ: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) state_n = flush ? IDLE  : DONE;
          else                  state_n = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (bus.data_data_ok) state_n = flush ? IDLE : DONE;
        else if (flush)       state_n = DRAIN;
      end
      DRAIN: begin
        if (bus.data_data_ok) state_n = IDLE;
      end
      DONE: begin
        if (pipe_adv | flush) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  logic is_load_q;
  logic ld_capture;

  always_comb begin
    bus.data_req = (state == REQ);
    stallreq     = (state == REQ) | (state == WAIT) | (state == DRAIN) | accept;
    ld_valid     = (state == DONE);
    addr_exc     = rst & (state == IDLE) & ex_valid & exc;
    // Capture only a response that leads to DONE for a load.
    ld_capture   = is_load_q & bus.data_data_ok & ~flush &
                   (((state == REQ) & bus.data_addr_ok) | (state == WAIT));
  end

  assign dbg_state = state;

  // ------------------------------------------------------------------
  // Datapath registers: request fields stay constant from accept to DONE.
  // ------------------------------------------------------------------
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wstrb_q   <= 4'b0000;
      wdata_q   <= 32'h0;
      is_load_q <= 1'b0;
    end else if (accept) begin
      wr_q      <= op_store;
      size_q    <= acc_size;
      addr_q    <= acc_addr;
      wstrb_q   <= acc_wstrb;
      wdata_q   <= acc_wdata;
      is_load_q <= ~op_store;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ld_rdata_q <= 32'h0;
    else if (ld_capture) ld_rdata_q <= bus.data_rdata;
  end

  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = wstrb_q;
  assign bus.data_wdata = wdata_q;
  assign ld_rdata       = ld_rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
// Directed and randomized scenarios for dmem_access_unit. Expected bus
// requests are queued when an access is driven and popped by a monitor at the
// cycle the bus takes the request. Load data and FSM status are checked inline
// in each scenario task.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int ADDR_W = 32;
  localparam int PW     = 1 + 2 + ADDR_W + 4 + 32;

  localparam logic [7:0] OP_LB  = 8'b1000_0000;
  localparam logic [7:0] OP_LH  = 8'b0010_0000;
  localparam logic [7:0] OP_LW  = 8'b0000_1000;
  localparam logic [7:0] OP_SB  = 8'b0000_0100;
  localparam logic [7:0] OP_SH  = 8'b0000_0010;
  localparam logic [7:0] OP_SW  = 8'b0000_0001;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // -------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              ex_valid  = 1'b0;
  logic [7:0]        ex_mem_op = 8'h0;
  logic [ADDR_W-1:0] ex_addr   = '0;
  logic [31:0]       ex_wdata  = 32'h0;
  logic              pipe_adv  = 1'b0;
  logic              flush     = 1'b0;
  logic              stallreq;
  logic [31:0]       ld_rdata;
  logic              ld_valid;
  logic              addr_exc;
  logic [2:0]        dbg_state;

  dmem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_mem_op (ex_mem_op),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .pipe_adv  (pipe_adv),
    .flush     (flush),
    .bus       (bus.master),
    .stallreq  (stallreq),
    .ld_rdata  (ld_rdata),
    .ld_valid  (ld_valid),
    .addr_exc  (addr_exc),
    .dbg_state (dbg_state)
  );

  // -------------------------------------------------------------- scoreboard
  logic [PW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   last_ld = 32'h0;

  function automatic logic [PW-1:0] pkt(input logic wr, input logic [1:0] size,
                                        input logic [31:0] addr, input logic [3:0] strb,
                                        input logic [31:0] wd);
    return {wr, size, addr, strb, wd};
  endfunction

  // Reference model for randomized accesses (aligned addresses only).
  function automatic logic [PW-1:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] wd);
    logic [1:0]  sz;
    logic [3:0]  st;
    logic [31:0] d;
    logic        w;
    w  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    st = 4'b0000;
    d  = 32'h0;
    if (op[7] || op[6] || op == OP_SB)      sz = 2'd0;
    else if (op[5] || op[4] || op == OP_SH) sz = 2'd1;
    else                                    sz = 2'd2;
    case (op)
      OP_SB: begin
        case (a[1:0])
          2'd0: st = 4'b0001;
          2'd1: st = 4'b0010;
          2'd2: st = 4'b0100;
          default: st = 4'b1000;
        endcase
        d = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end
      OP_SH: begin
        st = a[1] ? 4'b1100 : 4'b0011;
        d  = {wd[15:0], wd[15:0]};
      end
      OP_SW: begin
        st = 4'b1111;
        d  = wd;
      end
      default: ;
    endcase
    return {w, sz, a, st, d};
  endfunction

  // Monitor: request stability while held, and request contents at acceptance.
  logic          prev_req = 1'b0;
  logic [PW-1:0] prev_pkt = '0;
  always @(negedge clk) begin
    logic [PW-1:0] cur;
    logic [PW-1:0] exp;
    cur = {bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb, bus.data_wdata};
    if (prev_req && bus.data_req) begin
      n_vec++;
      if (cur !== prev_pkt) begin
        n_err++;
        $display("FAIL req_stable: got %h, required %h", cur, prev_pkt);
      end
    end
    if (bus.data_req && bus.data_addr_ok) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got %h, required no request", cur);
      end else begin
        exp = exp_q.pop_front();
        // Load write data is don't-care.
        if (!exp[PW-1]) begin
          exp[31:0] = cur[31:0];
        end
        if (cur !== exp) begin
          n_err++;
          $display("FAIL req_fields: got %h, required %h", cur, exp);
        end
      end
    end
    prev_req = bus.data_req;
    prev_pkt = cur;
  end

  // -------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd);
    ex_valid  = 1'b1;
    ex_mem_op = op;
    ex_addr   = a;
    ex_wdata  = wd;
  endtask

  // From the accept cycle: REQ, optional addr_ok delay, WAIT with data_ok, land in DONE.
  task automatic run_bus(input int addr_dly, input logic [31:0] rd);
    tick();
    repeat (addr_dly) tick();
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = rd;
    tick();
    bus.data_data_ok = 1'b0;
  endtask

  task automatic release_done();
    ex_valid = 1'b0;
    pipe_adv = 1'b1;
    tick();
    pipe_adv = 1'b0;
  endtask

  // -------------------------------------------------------------- scenarios
  task automatic test_reset();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    rst = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb,
         bus.data_wdata, stallreq, ld_rdata, ld_valid, addr_exc, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b addr=%h st=%0d ld=%h, required all 0",
               bus.data_req, bus.data_addr, dbg_state, ld_rdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_basic();
    drive_ex(OP_LW, 32'h100, 32'h0);
    exp_q.push_back(pkt(1'b0, 2'd2, 32'h100, 4'b0000, 32'h0));
    #1;
    n_vec++;
    if (stallreq !== 1'b1) begin n_err++; $display("FAIL lw_stall_T: got %b, required 1", stallreq); end
    tick();
    bus.data_addr_ok = 1'b1;
    #1;
    n_vec++;
    if ({bus.data_req, stallreq, dbg_state} !== {1'b1, 1'b1, S_REQ}) begin
      n_err++; $display("FAIL lw_T1: got req=%b stall=%b st=%0d, required 1 1 %0d", bus.data_req, stallreq, dbg_state, S_REQ);
    end
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEADBEEF;
    #1;
    n_vec++;
    if ({bus.data_req, stallreq, dbg_state} !== {1'b0, 1'b1, S_WAIT}) begin
      n_err++; $display("FAIL lw_T2: got req=%b stall=%b st=%0d, required 0 1 %0d", bus.data_req, stallreq, dbg_state, S_WAIT);
    end
    tick();
    bus.data_data_ok = 1'b0;
    n_vec++;
    if ({ld_valid, stallreq, ld_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL lw_done: got vld=%b stall=%b ld=%h, required 1 0 deadbeef", ld_valid, stallreq, ld_rdata);
    end
    last_ld = 32'hDEADBEEF;
    tick();
    n_vec++;
    if (ld_valid !== 1'b1) begin n_err++; $display("FAIL lw_hold: got %b, required 1", ld_valid); end
    release_done();
    n_vec++;
    if ({ld_valid, dbg_state} !== {1'b0, S_IDLE}) begin
      n_err++; $display("FAIL lw_release: got vld=%b st=%0d, required 0 0", ld_valid, dbg_state);
    end
  endtask

  task automatic test_store_byte();
    drive_ex(OP_SB, 32'h103, 32'h000000A5);
    exp_q.push_back(pkt(1'b1, 2'd0, 32'h103, 4'b1000, 32'hA5A5A5A5));
    run_bus(0, 32'h5555_0000);
    n_vec++;
    if ({ld_valid, ld_rdata} !== {1'b1, last_ld}) begin
      n_err++; $display("FAIL sb_ld_keep: got vld=%b ld=%h, required 1 %h", ld_valid, ld_rdata, last_ld);
    end
    release_done();
  endtask

  task automatic test_store_half();
    drive_ex(OP_SH, 32'h102, 32'h00001234);
    exp_q.push_back(pkt(1'b1, 2'd1, 32'h102, 4'b1100, 32'h12341234));
    run_bus(0, 32'h0);
    n_vec++;
    if (ld_valid !== 1'b1) begin n_err++; $display("FAIL sh_done: got %b, required 1", ld_valid); end
    release_done();
  endtask

  task automatic test_addr_ok_delay();
    drive_ex(OP_LW, 32'h200, 32'h0);
    exp_q.push_back(pkt(1'b0, 2'd2, 32'h200, 4'b0000, 32'h0));
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({bus.data_req, stallreq, bus.data_addr} !== {1'b1, 1'b1, 32'h200}) begin
        n_err++; $display("FAIL dly_hold%0d: got req=%b stall=%b addr=%h, required 1 1 200", i, bus.data_req, stallreq, bus.data_addr);
      end
      tick();
    end
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hCAFE0123;
    tick();
    bus.data_data_ok = 1'b0;
    n_vec++;
    if ({ld_valid, ld_rdata} !== {1'b1, 32'hCAFE0123}) begin
      n_err++; $display("FAIL dly_done: got vld=%b ld=%h, required 1 cafe0123", ld_valid, ld_rdata);
    end
    last_ld = 32'hCAFE0123;
    release_done();
  endtask

  task automatic test_flush_wait();
    drive_ex(OP_LW, 32'h300, 32'h0);
    exp_q.push_back(pkt(1'b0, 2'd2, 32'h300, 4'b0000, 32'h0));
    tick();
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    flush    = 1'b1;
    ex_valid = 1'b0;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({dbg_state, stallreq, ld_valid} !== {S_DRAIN, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL flush_drain: got st=%0d stall=%b vld=%b, required %0d 1 0", dbg_state, stallreq, ld_valid, S_DRAIN);
    end
    tick();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h11111111;
    tick();
    bus.data_data_ok = 1'b0;
    n_vec++;
    if ({dbg_state, stallreq, ld_valid, ld_rdata} !== {S_IDLE, 1'b0, 1'b0, last_ld}) begin
      n_err++; $display("FAIL flush_idle: got st=%0d stall=%b vld=%b ld=%h, required 0 0 0 %h", dbg_state, stallreq, ld_valid, ld_rdata, last_ld);
    end
  endtask

  task automatic test_flush_req();
    drive_ex(OP_LW, 32'h500, 32'h0);
    tick();
    flush    = 1'b1;
    ex_valid = 1'b0;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({dbg_state, bus.data_req, stallreq} !== {S_IDLE, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL flush_req: got st=%0d req=%b stall=%b, required 0 0 0", dbg_state, bus.data_req, stallreq);
    end
  endtask

  task automatic test_misaligned();
`ifdef DMEM_ALIGN_CHECK_EN
    drive_ex(OP_LH, 32'h101, 32'h0);
    #1;
    n_vec++;
    if ({addr_exc, stallreq} !== {1'b1, 1'b0}) begin
      n_err++; $display("FAIL mis_exc: got exc=%b stall=%b, required 1 0", addr_exc, stallreq);
    end
    repeat (2) tick();
    n_vec++;
    if ({bus.data_req, dbg_state, addr_exc} !== {1'b0, S_IDLE, 1'b1}) begin
      n_err++; $display("FAIL mis_noreq: got req=%b st=%0d exc=%b, required 0 0 1", bus.data_req, dbg_state, addr_exc);
    end
    ex_valid = 1'b0;
    tick();
`else
    drive_ex(OP_LH, 32'h101, 32'h0);
    exp_q.push_back(pkt(1'b0, 2'd1, 32'h100, 4'b0000, 32'h0));
    #1;
    n_vec++;
    if ({addr_exc, stallreq} !== {1'b0, 1'b1}) begin
      n_err++; $display("FAIL mis_exc: got exc=%b stall=%b, required 0 1", addr_exc, stallreq);
    end
    run_bus(0, 32'h0000ABCD);
    last_ld = 32'h0000ABCD;
    release_done();
    drive_ex(OP_LW, 32'h107, 32'h0);
    exp_q.push_back(pkt(1'b0, 2'd2, 32'h104, 4'b0000, 32'h0));
    run_bus(1, 32'h89ABCDEF);
    n_vec++;
    if (ld_rdata !== 32'h89ABCDEF) begin n_err++; $display("FAIL mis_lw: got %h, required 89abcdef", ld_rdata); end
    last_ld = 32'h89ABCDEF;
    release_done();
`endif
  endtask

  task automatic test_async_reset();
    drive_ex(OP_LW, 32'h400, 32'h0);
    exp_q.push_back(pkt(1'b0, 2'd2, 32'h400, 4'b0000, 32'h0));
    tick();
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.data_req, bus.data_addr, stallreq, ld_valid, ld_rdata, dbg_state} !== '0) begin
      n_err++; $display("FAIL areset: got req=%b addr=%h stall=%b st=%0d, required all 0", bus.data_req, bus.data_addr, stallreq, dbg_state);
    end
    last_ld = 32'h0;
    ex_addr = 32'h404;
    exp_q.push_back(pkt(1'b0, 2'd2, 32'h404, 4'b0000, 32'h0));
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (stallreq !== 1'b1) begin n_err++; $display("FAIL areset_accept: got %b, required 1", stallreq); end
    run_bus(0, 32'h0BADF00D);
    n_vec++;
    if ({ld_valid, ld_rdata} !== {1'b1, 32'h0BADF00D}) begin
      n_err++; $display("FAIL areset_lw: got vld=%b ld=%h, required 1 0badf00d", ld_valid, ld_rdata);
    end
    last_ld = 32'h0BADF00D;
    release_done();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  op;
    logic [31:0] a, wd, rd;
    bit          is_st;
    for (int i = 0; i < 10; i++) begin
      op = 8'b1000_0000 >> $urandom_range(0, 7);
      a  = 32'h1000 + ($urandom_range(0, 63) << 2);
      if (op[7] || op[6] || op == OP_SB)      a = a + $urandom_range(0, 3);
      else if (op[5] || op[4] || op == OP_SH) a = a + ($urandom_range(0, 1) * 2);
      wd    = $urandom;
      rd    = $urandom;
      is_st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
      drive_ex(op, a, wd);
      exp_q.push_back(model(op, a, wd));
      run_bus($urandom_range(0, 2), rd);
      if (!is_st) last_ld = rd;
      n_vec++;
      if ({ld_valid, ld_rdata} !== {1'b1, last_ld}) begin
        n_err++; $display("FAIL b2b_%0d: got vld=%b ld=%h, required 1 %h", i, ld_valid, ld_rdata, last_ld);
      end
      release_done();
    end
  endtask

  // -------------------------------------------------------------- main
  initial begin
    test_reset();
    test_load_basic();
    test_store_byte();
    test_store_half();
    test_addr_ok_delay();
    test_flush_wait();
    test_flush_req();
    test_misaligned();
    test_async_reset();
    test_back_to_back();
    repeat (2) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
